// File: rtl/conv_pkg.sv
// Shared widths and arithmetic helpers for the streaming KxKxCH convolver.
// Pure functions only; no state, no latency, no flow control.
// Imported by conv_window_kxk and conv_kkc_stream.
package conv_pkg;

    function automatic int conv_acc_w(input int bit_width, input int ntaps);
        return 2 * bit_width + $clog2(ntaps) + 1;
    endfunction

    function automatic int conv_fidx(input int c, input int r, input int q, input int k);
        return c * k * k + r * k + q;
    endfunction

    // ReLU first, then clamp to the ow-bit signed range or wrap to its low ow bits.
    function automatic logic signed [63:0] conv_relu_sat(input logic signed [63:0] v,
                                                         input int ow,
                                                         input bit relu,
                                                         input bit sat);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = v;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (relu && r < 0) begin
            r = '0;
        end
        if (sat) begin
            if (r > hi) begin
                r = hi;
            end else if (r < lo) begin
                r = lo;
            end
        end else begin
            r = (r <<< (64 - ow)) >>> (64 - ow);
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_window_kxk.sv
// Per-channel K-1 line buffers feeding a KxK shift window; row 0/col 0 is the oldest tap.
// Window reflects the accepted pixel one cycle after the beat.
// No backpressure: storage shifts only on in_valid and holds through gaps.
module conv_window_kxk
    import conv_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int MAP_SIZE  = 14,
    parameter int K         = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [BIT_WIDTH-1:0]       pixel,
    output logic [K*K*BIT_WIDTH-1:0]   window
);

    localparam int LB_LEN = (K - 1) * MAP_SIZE;

    logic [BIT_WIDTH-1:0] lb_q  [LB_LEN];
    logic [BIT_WIDTH-1:0] win_q [K][K];
    logic [BIT_WIDTH-1:0] col_in [K];

    // lb_q[j] holds the pixel accepted j+1 beats ago, so a tap at d*MAP_SIZE-1 is d rows up.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            col_in[r] = (r == K - 1) ? pixel : lb_q[(K - 1 - r) * MAP_SIZE - 1];
        end
    end

    // Contents are deliberately not reset; the top gates outputs with its counters.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            lb_q[0] <= pixel;
            for (int j = 1; j < LB_LEN; j++) begin
                lb_q[j] <= lb_q[j-1];
            end
            for (int r = 0; r < K; r++) begin
                for (int q = 0; q < K - 1; q++) begin
                    win_q[r][q] <= win_q[r][q+1];
                end
                win_q[r][K-1] <= col_in[r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar q = 0; q < K; q++) begin : g_col
            assign window[(r*K+q)*BIT_WIDTH +: BIT_WIDTH] = win_q[r][q];
        end
    end

endmodule

// File: rtl/conv_kkc_stream.sv
// Streaming KxKxCH convolution: one biased, optionally ReLU'd and saturated sum per valid window.
// Latency: out_valid 3 cycles after the beat completing the window (products, sum, output stage).
// No backpressure: pipeline always advances; in_valid gaps only stall the line buffers.
module conv_kkc_stream
    import conv_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int MAP_SIZE  = 14,
    parameter int K         = 5,
    parameter int CH        = 3,
    parameter int RELU      = 0,
    parameter int SATURATE  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              frame_start,
    input  logic [BIT_WIDTH*CH-1:0]           pixels,
    input  logic [BIT_WIDTH*K*K*CH-1:0]       filter,
    input  logic [BIT_WIDTH-1:0]              bias,
    output logic                              out_valid,
    output logic                              out_last,
    output logic signed [OUT_WIDTH-1:0]       conv_value
);

    localparam int NTAP  = CH * K * K;
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int ACC_W = conv_acc_w(BIT_WIDTH, NTAP);
    localparam int CW    = $clog2(MAP_SIZE);
    localparam logic [CW-1:0] KM1  = CW'(K - 1);
    localparam logic [CW-1:0] LAST = CW'(MAP_SIZE - 1);

    logic [CW-1:0] col_q, col_d, row_q, row_d, cur_col, cur_row;
    logic          hit, hit_last;

    // frame_start re-labels the current beat as (0,0) before it is used for gating.
    always_comb begin
        cur_col  = (in_valid && frame_start) ? '0 : col_q;
        cur_row  = (in_valid && frame_start) ? '0 : row_q;
        col_d    = col_q;
        row_d    = row_q;
        if (in_valid) begin
            if (cur_col == LAST) begin
                col_d = '0;
                row_d = (cur_row == LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
        hit      = in_valid && (cur_row >= KM1) && (cur_col >= KM1);
        hit_last = hit && (cur_row == LAST) && (cur_col == LAST);
    end

    logic [K*K*BIT_WIDTH-1:0] win [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        conv_window_kxk #(
            .BIT_WIDTH (BIT_WIDTH),
            .MAP_SIZE  (MAP_SIZE),
            .K         (K)
        ) u_win (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .pixel    (pixels[c*BIT_WIDTH +: BIT_WIDTH]),
            .window   (win[c])
        );
    end

    logic signed [PW-1:0] prod_d [NTAP];
    logic signed [PW-1:0] prod_q [NTAP];

    for (genvar c = 0; c < CH; c++) begin : g_mc
        for (genvar r = 0; r < K; r++) begin : g_mr
            for (genvar q = 0; q < K; q++) begin : g_mq
                localparam int IDX = conv_fidx(c, r, q, K);
                assign prod_d[IDX] =
                    PW'($signed(win[c][(r*K+q)*BIT_WIDTH +: BIT_WIDTH])) *
                    PW'($signed(filter[IDX*BIT_WIDTH +: BIT_WIDTH]));
            end
        end
    end

    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic signed [ACC_W:0]   biased;
    logic signed [OUT_WIDTH-1:0] conv_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NTAP; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
        biased = (ACC_W+1)'(sum_q) + (ACC_W+1)'($signed(bias));
        conv_d = OUT_WIDTH'(conv_relu_sat(64'(biased), OUT_WIDTH, RELU != 0, SATURATE != 0));
    end

    // Datapath registers carry no reset; only the valid chain and outputs are cleared.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

    logic v0_q, v1_q, v2_q, l0_q, l1_q, l2_q;
    logic out_valid_q, out_last_q;
    logic signed [OUT_WIDTH-1:0] conv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l0_q        <= 1'b0;
            l1_q        <= 1'b0;
            l2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            conv_q      <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            v0_q        <= hit;
            l0_q        <= hit_last;
            v1_q        <= v0_q;
            l1_q        <= l0_q;
            v2_q        <= v1_q;
            l2_q        <= l1_q;
            out_valid_q <= v2_q;
            out_last_q  <= l2_q;
            if (v2_q) begin
                conv_q <= conv_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign conv_value = conv_q;

endmodule

// File: tb/tb_conv_kkc_stream.sv
// Scoreboarded bench: three DUT variants (32-bit sat, 16-bit sat, 16-bit wrap+ReLU) share stimulus.
module tb_conv_kkc_stream;

    localparam int BW = 8;
    localparam int MS = 14;
    localparam int K  = 5;
    localparam int CH = 3;
    localparam int NT = CH * K * K;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, frame_start;
    logic [BW*CH-1:0] pixels;
    logic [BW*NT-1:0] filter;
    logic [BW-1:0]    bias;

    logic ov_a, ol_a, ov_b, ol_b, ov_c, ol_c;
    logic signed [31:0] cv_a;
    logic signed [15:0] cv_b, cv_c;

    always #5 clk = ~clk;

    conv_kkc_stream #(.OUT_WIDTH(32), .RELU(0), .SATURATE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .pixels(pixels), .filter(filter), .bias(bias),
        .out_valid(ov_a), .out_last(ol_a), .conv_value(cv_a));

    conv_kkc_stream #(.OUT_WIDTH(16), .RELU(0), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .pixels(pixels), .filter(filter), .bias(bias),
        .out_valid(ov_b), .out_last(ol_b), .conv_value(cv_b));

    conv_kkc_stream #(.OUT_WIDTH(16), .RELU(1), .SATURATE(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .pixels(pixels), .filter(filter), .bias(bias),
        .out_valid(ov_c), .out_last(ol_c), .conv_value(cv_c));

    logic ov [3];
    logic ol [3];
    int   cv [3];
    assign ov[0] = ov_a;
    assign ov[1] = ov_b;
    assign ov[2] = ov_c;
    assign ol[0] = ol_a;
    assign ol[1] = ol_b;
    assign ol[2] = ol_c;
    assign cv[0] = cv_a;
    assign cv[1] = cv_b;
    assign cv[2] = cv_c;

    typedef struct {
        int v;
        bit last;
        int cyc;
    } exp_t;

    exp_t q [3][$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d (cycle %0d)", name, d, got, exp, cyc);
        end
    endtask

    // Hand-derived expected output for a window whose bottom-right pixel is (r,c).
    function automatic int expv(input int t, input int d, input int r, input int c);
        case (t)
            1: return 75;
            2: return ((r - 2) * MS + (c - 2)) % 128;
            3: return (d == 2) ? 0 : -128;
            4: return (d == 0) ? 1209675 : ((d == 1) ? 32767 : 30027);
            default: return 0;
        endcase
    endfunction

    task automatic setup(input int t);
        filter = '0;
        bias   = '0;
        for (int i = 0; i < NT; i++) begin
            if (t == 1) filter[i*BW +: BW] = 8'd1;
            if (t == 4) filter[i*BW +: BW] = 8'd127;
        end
        if (t == 2) filter[37*BW +: BW] = 8'd1;
        if (t == 3) bias = 8'h80;
    endtask

    task automatic beat(input int t, input int r, input int c, input bit fs);
        pixels = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (t == 1) pixels[ch*BW +: BW] = 8'd1;
            if (t == 4) pixels[ch*BW +: BW] = 8'd127;
        end
        if (t == 2) pixels[BW +: BW] = 8'((r * MS + c) % 128);
        in_valid    = 1'b1;
        frame_start = fs;
        if (r >= K - 1 && c >= K - 1) begin
            for (int d = 0; d < 3; d++) begin
                q[d].push_back('{expv(t, d, r, c), (r == MS - 1 && c == MS - 1), cyc + 4});
            end
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int t, input bit gaps, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
            beat(t, i / MS, i % MS, i == 0);
        end
        idle(8);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", d, int'(ov[d]), 0);
            chk("rst_last", d, int'(ol[d]), 0);
            chk("rst_value", d, cv[d], 0);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    if (q[d].size() == 0) begin
                        chk("unexpected_out", d, 1, 0);
                    end else begin
                        exp_t e;
                        e = q[d].pop_front();
                        chk("value", d, cv[d], e.v);
                        chk("last", d, int'(ol[d]), int'(e.last));
                        chk("cycle", d, cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        pixels      = '0;
        setup(1);
        idle(3);
        check_reset_outputs();
        rst = 1'b0;
        idle(2);

        setup(1); frame(1, 1'b0, MS * MS);
        setup(2); frame(2, 1'b0, MS * MS);
        setup(3); frame(3, 1'b0, MS * MS);
        setup(4); frame(4, 1'b0, MS * MS);
        setup(2); frame(2, 1'b1, MS * MS);
        setup(1); frame(1, 1'b1, MS * MS);

        // Reset mid-frame, then a clean frame.
        setup(1);
        for (int i = 0; i < 37; i++) beat(1, i / MS, i % MS, i == 0);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) q[d].delete();
        idle(2);
        check_reset_outputs();
        rst = 1'b0;
        idle(1);
        frame(1, 1'b0, MS * MS);

        // Abandon a partial frame with frame_start at beat 20.
        setup(2);
        for (int i = 0; i < 20; i++) beat(2, i / MS, i % MS, i == 0);
        frame(2, 1'b0, MS * MS);

        for (int d = 0; d < 3; d++) chk("leftover_expected", d, q[d].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
